// File: rtl/tx_cp_insert.sv
// Cyclic-prefix insertion: ping-pong buffers NFFT-sample symbols and replays the last NCP first.
// Optional TXCP_PAD_EN: zero-pad a partial symbol at CYC_I fall instead of discarding it.
module tx_cp_insert #(
   parameter int unsigned NFFT = 64,
   parameter int unsigned NCP  = 16,
   parameter int unsigned DW   = 32
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [DW-1:0] DAT_I,
   input  logic          CYC_I,
   input  logic          WE_I,
   input  logic          STB_I,
   output logic          ACK_O,
   output logic [DW-1:0] DAT_O,
   output logic          CYC_O,
   output logic          STB_O,
   output logic          WE_O,
   input  logic          ACK_I
);

   localparam int unsigned AW = $clog2(NFFT);
   localparam int unsigned RW = $clog2(NFFT + NCP);
   localparam logic [AW-1:0] WrLast = AW'(NFFT - 1);
   localparam logic [RW-1:0] RdLast = RW'(NFFT + NCP - 1);
   localparam logic [RW-1:0] CpLen  = RW'(NCP);
   localparam logic [RW-1:0] CpBase = RW'(NFFT - NCP);

   logic [DW-1:0] mem_q [2][NFFT];

   logic [1:0]    full_q, full_d;
   logic          wb_q, wb_d, rb_q, rb_d;
   logic [AW-1:0] wr_cnt_q, wr_cnt_d;
   logic [RW-1:0] rd_cnt_q, rd_cnt_d;
   logic [DW-1:0] dat_q, dat_d;
   logic          stb_q, stb_d;
   logic          cyc_o_q, cyc_o_d;
   logic          cyc_i_q;
   logic          pad_q, pad_d;

   logic          ack;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic          pad_act;
   logic          discard;
   logic          out_halt;
   logic [RW-1:0] rd_addr_w;
   logic [AW-1:0] rd_addr;

   always_comb begin
      ack       = 1'b0;
      pad_act   = 1'b0;
      discard   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      full_d    = full_q;
      wb_d      = wb_q;
      wr_cnt_d  = wr_cnt_q;
      pad_d     = pad_q;
      rb_d      = rb_q;
      rd_cnt_d  = rd_cnt_q;
      dat_d     = dat_q;
      stb_d     = stb_q;
      cyc_o_d   = cyc_o_q;

`ifdef TXCP_PAD_EN
      // Padding owns the write port until the bank is complete.
      pad_act = pad_q | (~CYC_I & (wr_cnt_q != '0));
      ack     = CYC_I & STB_I & WE_I & ~full_q[wb_q] & ~pad_q & ~RST_I;
`else
      discard = ~CYC_I & (wr_cnt_q != '0);
      ack     = CYC_I & STB_I & WE_I & ~full_q[wb_q] & ~RST_I;
`endif

      mem_we    = ack | pad_act;
      mem_wdata = ack ? DAT_I : '0;

      // Read side first so a bank released and a bank filled in one cycle both land.
      out_halt  = stb_q & ~ACK_I;
      rd_addr_w = (rd_cnt_q < CpLen) ? (CpBase + rd_cnt_q) : (rd_cnt_q - CpLen);
      rd_addr   = rd_addr_w[AW-1:0];
      if (!out_halt) begin
         if (full_q[rb_q]) begin
            dat_d = mem_q[rb_q][rd_addr];
            stb_d = 1'b1;
            if (rd_cnt_q == RdLast) begin
               rd_cnt_d     = '0;
               rb_d         = ~rb_q;
               full_d[rb_q] = 1'b0;
            end else begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
         end else begin
            stb_d = 1'b0;
         end
      end

      if (mem_we) begin
         if (wr_cnt_q == WrLast) begin
            wr_cnt_d     = '0;
            wb_d         = ~wb_q;
            full_d[wb_q] = 1'b1;
            pad_d        = 1'b0;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            pad_d    = pad_act;
         end
      end else if (discard) begin
         wr_cnt_d = '0;
      end

      if (CYC_I && !cyc_i_q) begin
         cyc_o_d = 1'b1;
      end else if (!CYC_I && (full_q == 2'b00) && (wr_cnt_q == '0) && !stb_d) begin
         cyc_o_d = 1'b0;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (mem_we) begin
         mem_q[wb_q][wr_cnt_q] <= mem_wdata;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         full_q   <= 2'b00;
         wb_q     <= 1'b0;
         rb_q     <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         dat_q    <= '0;
         stb_q    <= 1'b0;
         cyc_o_q  <= 1'b0;
         cyc_i_q  <= 1'b0;
         pad_q    <= 1'b0;
      end else begin
         full_q   <= full_d;
         wb_q     <= wb_d;
         rb_q     <= rb_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         dat_q    <= dat_d;
         stb_q    <= stb_d;
         cyc_o_q  <= cyc_o_d;
         cyc_i_q  <= CYC_I;
         pad_q    <= pad_d;
      end
   end

   assign ACK_O = ack;
   assign DAT_O = dat_q;
   assign STB_O = stb_q;
   assign WE_O  = stb_q;
   assign CYC_O = cyc_o_q;

endmodule

// File: tb/tb_tx_cp_insert.sv
// Scoreboard bench for tx_cp_insert: expected beats queued per accepted symbol, popped per output beat.
module tb_tx_cp_insert;

   localparam int NFFT = 64;
   localparam int NCP  = 16;
   localparam int DW   = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] dat_i = '0;
   logic          cyc_i = 1'b0;
   logic          we_i = 1'b0;
   logic          stb_i = 1'b0;
   logic          ack_i = 1'b1;
   logic          ACK_O, CYC_O, STB_O, WE_O;
   logic [DW-1:0] DAT_O;

   tx_cp_insert #(.NFFT(NFFT), .NCP(NCP), .DW(DW)) dut (
      .CLK_I (clk),
      .RST_I (rst),
      .DAT_I (dat_i),
      .CYC_I (cyc_i),
      .WE_I  (we_i),
      .STB_I (stb_i),
      .ACK_O (ACK_O),
      .DAT_O (DAT_O),
      .CYC_O (CYC_O),
      .STB_O (STB_O),
      .WE_O  (WE_O),
      .ACK_I (ack_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int beat_cnt = 0;
   int run_len  = 0;
   int last_beat_cyc = -10;
   logic [DW-1:0] stim[$];
   logic [DW-1:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: a beat transfers on the next rising edge when STB_O and ACK_I are both high.
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst && STB_O && ack_i) begin
            beat_cnt++;
            run_len = (last_beat_cyc + 1 == cyc) ? run_len + 1 : 1;
            last_beat_cyc = cyc;
            if (exp_q.size() == 0) begin
               check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check_eq("beat_dat", 64'(DAT_O), 64'(e));
            end
         end
      end
   end

   task automatic push_sym(input int base);
      for (int i = 0; i < NCP; i++) exp_q.push_back(stim[base + NFFT - NCP + i]);
      for (int i = 0; i < NFFT; i++) exp_q.push_back(stim[base + i]);
   endtask

   // Streams stim[0..n-1]; gives up after max_stall consecutive refused cycles.
   task automatic drive(input int n, input int max_stall, output int acc);
      int stall;
      stall = 0;
      acc   = 0;
      cyc_i = 1'b1;
      we_i  = 1'b1;
      while (acc < n && stall < max_stall) begin
         stb_i = 1'b1;
         dat_i = stim[acc];
         @(negedge clk);
         if (ACK_O) begin
            @(posedge clk); #1;
            acc++;
            stall = 0;
            if (acc % NFFT == 0) push_sym(acc - NFFT);
         end else begin
            @(posedge clk); #1;
            stall++;
         end
      end
      stb_i = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int max);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < max) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_cyc_low(input string tag, input int max);
      int t;
      t = 0;
      while (CYC_O && t < max) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq(tag, 64'(CYC_O), 64'd0);
   endtask

   task automatic wait_beats(input int b0, input int n, input int max);
      int t;
      t = 0;
      while (beat_cnt - b0 < n && t < max) begin
         @(posedge clk); #1;
         t++;
      end
      check_eq("beat_reach", 64'(beat_cnt - b0 >= n), 64'd1);
   endtask

   initial begin
      int acc;
      int b0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_stb", 64'(STB_O), 64'd0);
      check_eq("rst_cyc", 64'(CYC_O), 64'd0);
      check_eq("rst_ack", 64'(ACK_O), 64'd0);
      check_eq("rst_dat", 64'(DAT_O), 64'd0);
      @(posedge clk); #1;

      // Single ramp symbol, latency and CYC_O release.
      stim.delete();
      for (int i = 0; i < NFFT; i++) stim.push_back(DW'(i));
      b0 = beat_cnt;
      drive(NFFT, 20, acc);
      cyc_i = 1'b0;
      @(negedge clk);
      check_eq("lat_stb_t1", 64'(STB_O), 64'd0);
      @(negedge clk);
      check_eq("lat_stb_t2", 64'(STB_O), 64'd1);
      check_eq("lat_dat_t2", 64'(DAT_O), 64'd48);
      wait_drain("t1_drain", 200);
      wait_cyc_low("t1_cyc_low", 20);
      check_eq("t1_beats", 64'(beat_cnt - b0), 64'd80);
      check_eq("t1_run", 64'(run_len), 64'd80);

      // Three streamed symbols must come out as one unbroken run.
      stim.delete();
      for (int i = 0; i < 3 * NFFT; i++) stim.push_back($urandom);
      b0 = beat_cnt;
      drive(3 * NFFT, 40, acc);
      check_eq("t2_acc", 64'(acc), 64'd192);
      cyc_i = 1'b0;
      wait_drain("t2_drain", 400);
      wait_cyc_low("t2_cyc_low", 20);
      check_eq("t2_beats", 64'(beat_cnt - b0), 64'd240);
      check_eq("t2_run", 64'(run_len), 64'd240);

      // Downstream stall of 10 cycles at beat 5.
      stim.delete();
      for (int i = 0; i < NFFT; i++) stim.push_back($urandom);
      b0 = beat_cnt;
      drive(NFFT, 20, acc);
      cyc_i = 1'b0;
      wait_beats(b0, 5, 100);
      ack_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_eq("t3_hold_stb", 64'(STB_O), 64'd1);
         check_eq("t3_hold_dat", 64'(DAT_O), 64'(exp_q[0]));
         @(posedge clk); #1;
      end
      ack_i = 1'b1;
      wait_drain("t3_drain", 200);
      wait_cyc_low("t3_cyc_low", 20);
      check_eq("t3_beats", 64'(beat_cnt - b0), 64'd80);

      // Permanent downstream stall: only two banks can be accepted.
      stim.delete();
      for (int i = 0; i < 3 * NFFT; i++) stim.push_back($urandom);
      ack_i = 1'b0;
      drive(3 * NFFT, 40, acc);
      check_eq("t4_acc", 64'(acc), 64'd128);
      stb_i = 1'b1;
      @(negedge clk);
      check_eq("t4_ack_low", 64'(ACK_O), 64'd0);
      @(posedge clk); #1;
      stb_i = 1'b0;
      cyc_i = 1'b0;
      b0 = beat_cnt;
      ack_i = 1'b1;
      wait_drain("t4_drain", 400);
      wait_cyc_low("t4_cyc_low", 20);
      check_eq("t4_beats", 64'(beat_cnt - b0), 64'd160);

      // Frame ends after 20 samples.
      stim.delete();
      for (int i = 0; i < 20; i++) stim.push_back(DW'(i));
      b0 = beat_cnt;
      drive(20, 20, acc);
      cyc_i = 1'b0;
`ifdef TXCP_PAD_EN
      for (int i = 0; i < NCP; i++) exp_q.push_back('0);
      for (int i = 0; i < 20; i++) exp_q.push_back(DW'(i));
      for (int i = 0; i < NFFT - 20; i++) exp_q.push_back('0);
      wait_drain("t5_drain", 300);
      wait_cyc_low("t5_cyc_low", 20);
      check_eq("t5_beats", 64'(beat_cnt - b0), 64'd80);
`else
      repeat (150) @(posedge clk);
      #1;
      check_eq("t5_beats", 64'(beat_cnt - b0), 64'd0);
      check_eq("t5_cyc_low", 64'(CYC_O), 64'd0);
`endif

      // Reset in the middle of output, then a clean symbol.
      stim.delete();
      for (int i = 0; i < NFFT; i++) stim.push_back(DW'(i + 100));
      b0 = beat_cnt;
      drive(NFFT, 20, acc);
      cyc_i = 1'b0;
      wait_beats(b0, 30, 100);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("t6_stb", 64'(STB_O), 64'd0);
      check_eq("t6_cyc", 64'(CYC_O), 64'd0);
      check_eq("t6_ack", 64'(ACK_O), 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      stim.delete();
      for (int i = 0; i < NFFT; i++) stim.push_back(DW'(3 * i + 7));
      b0 = beat_cnt;
      drive(NFFT, 20, acc);
      cyc_i = 1'b0;
      wait_drain("t6_drain", 200);
      wait_cyc_low("t6_cyc_low", 20);
      check_eq("t6_beats", 64'(beat_cnt - b0), 64'd80);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
